timer_arbiter: RTL and testbench

Round-robin controller that shares one external one-shot countdown timer between `N_REQ` requesters. It arbitrates among pending requests and loads the winner's duration into the timer. It then sequences the timer through its `tmr_start`/`tmr_rdy` handshake and returns a one-cycle completion pulse to the winner. It sits between the timer datapath and the FSMs that need timed delays, so they do not each instantiate a private counter.

---
 rtl/timer_arbiter.sv | 154 +++++++++++++++
 tb/tb_timer_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter
//
// Shares one external one-shot countdown timer between N_REQ requesters.
// A round-robin arbiter picks a pending requester while the timer is idle,
// captures that requester's duration, pulses tmr_start, follows the timer
// through its tmr_rdy handshake, and pulses done back to the winner.
//
// Every output is decoded from the state register and the captured
// registers only, so no input reaches an output combinationally.

module timer_arbiter #(
    parameter int N_REQ = 4,    // number of requesters, 2..8
    parameter int CW    = 16    // timer count width
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] dur,
    input  logic                tmr_rdy,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                tmr_start,
    output logic [CW-1:0]       tmr_count,
    output logic                busy
);

    // Width of a requester index; N_REQ is at least 2, so this is at least 1.
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE = 3'd0,    // waiting for a request while the timer is ready
        LOAD = 3'd1,    // grant asserted, timer started if duration non-zero
        ACK  = 3'd2,    // waiting for the timer to acknowledge (tmr_rdy low)
        RUN  = 3'd3,    // timer counting, waiting for tmr_rdy to return high
        DONE = 3'd4     // one-cycle completion pulse to the winner
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [IW-1:0]   ptr;        // index with highest priority next time
    logic [IW-1:0]   widx;       // captured winner of the current operation
    logic [IW-1:0]   win;        // combinational round-robin winner
    logic [IW-1:0]   ptr_nxt;    // pointer value after a win
    logic            found;      // some request bit is set
    logic            accept;     // IDLE takes a new request on this edge

    // Round-robin search: first set req bit starting at ptr, wrapping around.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // otherwise a path that skips the assignment infers a latch.
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            int unsigned idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Pointer moves one past the winner so that winner drops to lowest priority.
    always_comb begin
        ptr_nxt = '0;
        if (win != IW'(N_REQ - 1)) begin
            ptr_nxt = win + 1'b1;
        end
    end

    assign accept = (state == IDLE) && found && tmr_rdy;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with <= so every register samples
        // the pre-edge value of the others, independent of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the start/acknowledge/complete handshake.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                state_nxt = accept ? LOAD : IDLE;
            end
            LOAD: begin
                // A zero duration never starts the timer and completes at once.
                state_nxt = (tmr_count != '0) ? ACK : DONE;
            end
            ACK: begin
                state_nxt = tmr_rdy ? ACK : RUN;
            end
            RUN: begin
                state_nxt = tmr_rdy ? DONE : RUN;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winner, its duration and the new pointer on acceptance;
    // later req/dur changes are ignored until the operation finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            widx      <= '0;
            tmr_count <= '0;
        end else if (accept) begin
            ptr       <= ptr_nxt;
            widx      <= win;
            tmr_count <= dur[int'(win)*CW +: CW];
        end
    end

    // Output decode from state and captured winner only.
    always_comb begin
        logic [N_REQ-1:0] onehot;
        onehot    = N_REQ'(1) << widx;
        gnt       = '0;
        done      = '0;
        tmr_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            LOAD: begin
                gnt       = onehot;
                tmr_start = (tmr_count != '0);
            end
            ACK, RUN: begin
                gnt = onehot;
            end
            DONE: begin
                gnt  = onehot;
                done = onehot;
            end
            default: begin
                gnt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter
//
// Directed bench for timer_arbiter with a model one-shot timer. The timer
// drops tmr_rdy one cycle after tmr_start and keeps it low for exactly
// tmr_count cycles, so done arrives D+2 clock edges after the accepting edge
// (D+3 cycles counting the accepting cycle), and one edge after acceptance
// for a zero duration.

module tb_timer_arbiter;

    localparam int N_REQ = 4;
    localparam int CW    = 16;

    logic                clk       = 1'b0;
    logic                reset     = 1'b1;
    logic [N_REQ-1:0]    req       = '0;
    logic [N_REQ*CW-1:0] dur       = '0;
    logic                hold_busy = 1'b0;
    logic                tmr_rdy;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic                tmr_start;
    logic [CW-1:0]       tmr_count;
    logic                busy;

    // Model timer state.
    logic                t_rdy = 1'b1;
    logic [CW-1:0]       t_cnt = '0;

    int n_cmp       = 0;
    int n_err       = 0;
    int start_cnt   = 0;
    int overlap_cnt = 0;

    timer_arbiter #(.N_REQ(N_REQ), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dur       (dur),
        .tmr_rdy   (tmr_rdy),
        .gnt       (gnt),
        .done      (done),
        .tmr_start (tmr_start),
        .tmr_count (tmr_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // hold_busy models the timer being in use elsewhere.
    assign tmr_rdy = t_rdy & ~hold_busy;

    // One-shot timer: load on start, count down, raise ready after D low cycles.
    always @(posedge clk) begin
        if (tmr_start) begin
            t_cnt <= tmr_count;
            t_rdy <= 1'b0;
        end else if (!t_rdy) begin
            t_cnt <= t_cnt - 1'b1;
            if (t_cnt == 1) begin
                t_rdy <= 1'b1;
            end
        end
    end

    // Mid-cycle monitor: count start pulses and any overlapping grants.
    always @(negedge clk) begin
        if (tmr_start) begin
            start_cnt <= start_cnt + 1;
        end
        if ($countones(gnt) > 1) begin
            overlap_cnt <= overlap_cnt + 1;
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, required end before 200000");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    // Edges from now until done is seen; 200 if it never arrives.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick;
            n++;
            if (done != '0) break;
        end
    endtask

    // Edges from now until a grant is seen; 200 if it never arrives.
    task automatic wait_grant(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick;
            n++;
            if (gnt != '0) break;
        end
    endtask

    initial begin
        int n;
        int s0;
        logic [N_REQ-1:0] order [5];
        order[0] = 4'b0010;
        order[1] = 4'b0100;
        order[2] = 4'b1000;
        order[3] = 4'b0001;
        order[4] = 4'b0010;

        // Reset state.
        tick;
        tick;
        check("rst_gnt",   32'(gnt),       32'h0);
        check("rst_done",  32'(done),      32'h0);
        check("rst_start", 32'(tmr_start), 32'h0);
        check("rst_count", 32'(tmr_count), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        reset = 1'b0;
        tick;
        check("idle_busy", 32'(busy), 32'h0);

        // 1: single request, D=5, done 7 edges after acceptance.
        dur[0*CW +: CW] = 16'd5;
        req = 4'b0001;
        s0 = start_cnt;
        tick;
        check("t1_gnt",   32'(gnt),       32'h1);
        check("t1_start", 32'(tmr_start), 32'h1);
        check("t1_count", 32'(tmr_count), 32'd5);
        check("t1_busy",  32'(busy),      32'h1);
        wait_done(n);
        check("t1_lat",    32'(n),             32'd7);
        check("t1_done",   32'(done),          32'h1);
        check("t1_starts", 32'(start_cnt - s0), 32'd1);
        req = 4'b0000;
        tick;
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_idle_gnt",  32'(gnt),  32'h0);
        check("t1_idle_done", 32'(done), 32'h0);

        // 2: all requesting, D=2; pointer is 1 after the previous win.
        for (int i = 0; i < N_REQ; i++) begin
            dur[i*CW +: CW] = 16'd2;
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(n);
            check("t2_gnt", 32'(gnt), 32'(order[i]));
            wait_done(n);
            check("t2_lat",  32'(n),    32'd4);
            check("t2_done", 32'(done), 32'(order[i]));
            if (i == 4) req = 4'b0000;
            tick;
            check("t2_gap", 32'(gnt), 32'h0);
        end
        check("t2_overlap", 32'(overlap_cnt), 32'd0);

        // 3: zero duration, done one edge after acceptance, no start.
        dur[2*CW +: CW] = 16'd0;
        req = 4'b0100;
        s0 = start_cnt;
        tick;
        check("t3_gnt",   32'(gnt),       32'h4);
        check("t3_start", 32'(tmr_start), 32'h0);
        check("t3_count", 32'(tmr_count), 32'h0);
        wait_done(n);
        check("t3_lat",  32'(n),    32'd1);
        check("t3_done", 32'(done), 32'h4);
        req = 4'b0000;
        tick;
        check("t3_starts", 32'(start_cnt - s0), 32'd0);

        // 4: timer busy elsewhere blocks the grant until tmr_rdy rises.
        hold_busy = 1'b1;
        dur[1*CW +: CW] = 16'd6;
        req = 4'b0010;
        tick;
        tick;
        tick;
        check("t4_nogrant", 32'(gnt),  32'h0);
        check("t4_idle",    32'(busy), 32'h0);
        hold_busy = 1'b0;
        tick;
        check("t4_gnt",   32'(gnt),       32'h2);
        check("t4_count", 32'(tmr_count), 32'd6);
        check("t4_start", 32'(tmr_start), 32'h1);

        // 5: drop req and change dur during RUN; operation completes unchanged.
        tick;
        tick;
        check("t5_busy",  32'(busy),      32'h1);
        check("t5_start", 32'(tmr_start), 32'h0);
        req = 4'b0000;
        dur[1*CW +: CW] = 16'd9;
        tick;
        check("t5_count", 32'(tmr_count), 32'd6);
        check("t5_gnt",   32'(gnt),       32'h2);
        wait_done(n);
        check("t5_lat",        32'(n),         32'd5);
        check("t5_done",       32'(done),      32'h2);
        check("t5_count_done", 32'(tmr_count), 32'd6);
        tick;
        check("t5_idle", 32'(busy), 32'h0);

        // 6: reset during RUN, then pointer restarts at 0.
        dur[0*CW +: CW] = 16'd10;
        req = 4'b0001;
        tick;
        check("t6_gnt_pre", 32'(gnt), 32'h1);
        tick;
        tick;
        reset = 1'b1;
        #1;
        check("t6_rst_gnt",   32'(gnt),       32'h0);
        check("t6_rst_done",  32'(done),      32'h0);
        check("t6_rst_start", 32'(tmr_start), 32'h0);
        check("t6_rst_count", 32'(tmr_count), 32'h0);
        check("t6_rst_busy",  32'(busy),      32'h0);
        req = 4'b1001;
        tick;
        tick;
        check("t6_hold_gnt", 32'(gnt), 32'h0);
        reset = 1'b0;
        tick;
        check("t6_nodone", 32'(done), 32'h0);
        check("t6_idle",   32'(busy), 32'h0);
        wait_grant(n);
        check("t6_gnt", 32'(gnt), 32'h1);
        wait_done(n);
        check("t6_lat",  32'(n),    32'd12);
        check("t6_done", 32'(done), 32'h1);
        req = 4'b0000;
        tick;
        check("t6_end_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
